// File: rtl/fetch_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_pkg: shared fetch/decode structures, FSM encoding, defaults |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package fetch_pkg;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
  localparam int unsigned FETCH_DEPTH    = 2;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instruction_value;
    logic [31:0] pc_value;
    logic        pc_r;
  } fe_to_de_s;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_s;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_if: request/response bus between fetch and instruction mem  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_buffer: DEPTH-entry shift FIFO of {instr, pc}; head at [0]  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  fetch_entry_s                 din,
  output fetch_entry_s                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_entry_s  r_mem [DEPTH];
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_wr_idx;

  // With a simultaneous pop the tail slides down one slot before the write lands.
  assign w_wr_idx = pop ? (r_count - CW'(1)) : r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (push && (w_wr_idx == CW'(i))) r_mem[i] <= din;
        else if (pop)                     r_mem[i] <= r_mem[(i + 1) % int'(DEPTH)];
      end
      r_count <= r_count + CW'(push) - CW'(pop);
    end
  end

  assign head  = r_mem[0];
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch: RV32 fetch stage, in-order variable-latency imem, redirect |
// |   discard; FETCH_PREFETCH_EN enables DEPTH-deep prefetch.         |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
  parameter int unsigned DEPTH    = FETCH_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        pc_r,
  input  logic [31:0] pc_new,
  fetch_if.master     imem,
  output fe_to_de_s   fe_to_de
);

`ifdef FETCH_PREFETCH_EN
  localparam int unsigned CAP = DEPTH;
`else
  // Single-slot mode: one word in flight or held for a stalled decode.
  localparam int unsigned CAP = (DEPTH < 1) ? DEPTH : 1;
`endif
  localparam int unsigned CW = $clog2(CAP + 1);

  fetch_state_e  r_state, w_state_next;
  logic [31:0]   r_fetch_pc, r_resp_pc;
  logic [CW-1:0] r_outstanding, r_discard;
  logic [CW-1:0] w_outstanding_next, w_discard_next;
  logic [CW-1:0] w_buf_count;
  logic [CW:0]   w_total;
  logic          w_req, w_issue, w_keep, w_bypass, w_push, w_pop;
  fetch_entry_s  w_din, w_head;
  fe_to_de_s     r_fe;

  assign w_total  = {1'b0, r_outstanding} + {1'b0, w_buf_count};
  assign w_issue  = w_req && imem.imem_gnt;
  assign w_keep   = imem.imem_rvalid && (r_discard == '0);
  assign w_bypass = w_keep && (w_buf_count == '0) && en;
  assign w_pop    = en && (w_buf_count != '0);
  assign w_push   = w_keep && !w_bypass;
  assign w_din    = '{instr: imem.imem_rdata, pc: r_resp_pc};

  assign w_outstanding_next = r_outstanding + CW'(w_issue) - CW'(imem.imem_rvalid);
  // Every request still in flight after a redirect belongs to the old path.
  assign w_discard_next = pc_r ? w_outstanding_next
                               : (r_discard - CW'(imem.imem_rvalid && (r_discard != '0)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_BOOT;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    case (r_state)
      ST_BOOT:  w_state_next = ST_RUN;
      ST_RUN:   w_req = (w_total < (CW+1)'(CAP)) && !pc_r;
      ST_DRAIN: if (w_discard_next == '0) w_state_next = ST_RUN;
      default:  w_state_next = ST_BOOT;
    endcase
    if (pc_r) w_state_next = (w_discard_next != '0) ? ST_DRAIN : ST_RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_fe          <= '{instruction_value: '0, pc_value: RESET_PC, pc_r: 1'b1};
    end else begin
      r_outstanding <= w_outstanding_next;
      r_discard     <= w_discard_next;
      if (pc_r) begin
        r_fetch_pc <= word_align(pc_new);
        r_resp_pc  <= word_align(pc_new);
        r_fe.pc_r  <= 1'b1;
      end else begin
        if (w_issue) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_keep)  r_resp_pc  <= r_resp_pc + 32'd4;
        if (en) begin
          if (w_pop)         r_fe <= '{instruction_value: w_head.instr, pc_value: w_head.pc, pc_r: 1'b0};
          else if (w_bypass) r_fe <= '{instruction_value: imem.imem_rdata, pc_value: r_resp_pc, pc_r: 1'b0};
          else               r_fe.pc_r <= 1'b1;
        end
      end
    end
  end

  fetch_buffer #(
    .DEPTH (CAP)
  ) u_buffer (
    .clk   (clk),
    .rst   (rst),
    .clear (pc_r),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .head  (w_head),
    .count (w_buf_count)
  );

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_fetch_pc;
  assign fe_to_de       = r_fe;

endmodule
`default_nettype wire

// File: tb/tb_fetch.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fetch: randomized bench, in-order memory model + PC-stream ref |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_fetch;
  import fetch_pkg::*;

`ifdef FETCH_PREFETCH_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk, rst, en, pc_r;
  logic [31:0] pc_new;
  fe_to_de_s   fe_to_de;
  fetch_if     bus ();

  fetch #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .pc_r     (pc_r),
    .pc_new   (pc_new),
    .imem     (bus),
    .fe_to_de (fe_to_de)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; bit stale; } mreq_t;
  mreq_t       memq[$];
  int          n_cmp, n_err;
  int          cyc, last_due, since_rst, model_buf, delivered, first_valid, mark;
  int          gnt_pct, lat_min, lat_max;
  logic [31:0] exp_pc, exp_req_addr;
  fe_to_de_s   prev_fe;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check_eq(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    memq.delete();
    model_buf    = 0;
    exp_pc       = RST_PC;
    exp_req_addr = RST_PC;
    since_rst    = 0;
    first_valid  = 0;
    last_due     = cyc;
    prev_fe      = '{instruction_value: '0, pc_value: RST_PC, pc_r: 1'b1};
  endtask

  // Called at a negedge; rst rises between edges to exercise the asynchronous path.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check_eq("rst_req", bus.imem_req, 1'b0);
    check_eq("rst_addr", bus.imem_addr, RST_PC);
    check_eq("rst_fe", fe_to_de, {32'h0, RST_PC, 1'b1});
    en = 1'b0; pc_r = 1'b0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_cycle(input logic en_v, input logic pcr_v, input logic [31:0] pcn_v);
    logic        rv, gnt, req_now, exp_req, kept, issued;
    logic [31:0] addr_now, tgt;
    int          stale_cnt, lat, due;
    mreq_t       e;
    en = en_v; pc_r = pcr_v; pc_new = pcn_v;
    rv = (memq.size() > 0) && (memq[0].due <= cyc);
    bus.imem_rvalid = rv;
    if (rv) bus.imem_rdata = word_of(memq[0].addr);
    else    bus.imem_rdata = $urandom;
    gnt = ($urandom_range(99) < gnt_pct);
    bus.imem_gnt = gnt;
    #1;
    req_now  = bus.imem_req;
    addr_now = bus.imem_addr;
    stale_cnt = 0;
    foreach (memq[i]) if (memq[i].stale) stale_cnt++;
    exp_req = (since_rst >= 1) && !pcr_v && (stale_cnt == 0) && (memq.size() + model_buf < CAP);
    check_eq("imem_req", req_now, exp_req);
    if (req_now) check_eq("imem_addr", addr_now, exp_req_addr);
    issued = req_now && gnt;

    @(posedge clk);
    since_rst++;
    kept = 1'b0;
    if (rv) begin
      e = memq.pop_front();
      kept = !e.stale && !pcr_v;
    end
    if (issued) begin
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      memq.push_back('{addr: addr_now, due: due, stale: 1'b0});
      exp_req_addr = exp_req_addr + 32'd4;
    end
    if (pcr_v) begin
      tgt = pcn_v & 32'hFFFF_FFFC;
      foreach (memq[i]) memq[i].stale = 1'b1;
      model_buf    = 0;
      exp_pc       = tgt;
      exp_req_addr = tgt;
    end

    @(negedge clk);
    if (pcr_v) begin
      check_eq("redirect_bubble", fe_to_de.pc_r, 1'b1);
      check_eq("redirect_pc_hold", fe_to_de.pc_value, prev_fe.pc_value);
    end else if (en_v) begin
      if (model_buf + int'(kept) > 0) begin
        model_buf = model_buf + int'(kept) - 1;
        check_eq("out_valid", fe_to_de.pc_r, 1'b0);
        check_eq("out_pc", fe_to_de.pc_value, exp_pc);
        check_eq("out_instr", fe_to_de.instruction_value, word_of(exp_pc));
        exp_pc = exp_pc + 32'd4;
        delivered++;
        if (first_valid == 0) first_valid = since_rst;
      end else begin
        check_eq("bubble", fe_to_de.pc_r, 1'b1);
        check_eq("bubble_pc_hold", fe_to_de.pc_value, prev_fe.pc_value);
      end
    end else begin
      model_buf = model_buf + int'(kept);
      check_eq("stall_hold", fe_to_de, prev_fe);
    end
    prev_fe = fe_to_de;
    cyc++;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; delivered = 0; first_valid = 0; mark = 0;
    rst = 1'b1; en = 1'b0; pc_r = 1'b0; pc_new = '0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    do_reset();

    // Zero-wait memory, decode never stalls.
    repeat (22) run_cycle(1'b1, 1'b0, 32'h0);
    check_eq("first_instr_edge", first_valid, 3);
`ifdef FETCH_PREFETCH_EN
    check_eq("stream_count", delivered, 20);
`else
    check_eq("stream_count", delivered, 10);
`endif

    // Decode stall mid-stream.
    repeat (4) run_cycle(1'b0, 1'b0, 32'h0);
    repeat (8) run_cycle(1'b1, 1'b0, 32'h0);

    // Latency 3, redirect while in flight, second redirect while draining.
    lat_min = 3; lat_max = 3;
    repeat (6) run_cycle(1'b1, 1'b0, 32'h0);
    run_cycle(1'b1, 1'b1, 32'h0000_0100);
    run_cycle(1'b1, 1'b0, 32'h0);
    run_cycle(1'b1, 1'b1, 32'h0000_0202);
    mark = delivered;
    repeat (16) run_cycle(1'b1, 1'b0, 32'h0);
    check_eq("redirect_progress", delivered > mark, 1'b1);

    // Grant withheld for five cycles.
    lat_min = 1; lat_max = 2; gnt_pct = 0;
    repeat (5) run_cycle(1'b1, 1'b0, 32'h0);
    gnt_pct = 100;
    repeat (6) run_cycle(1'b1, 1'b0, 32'h0);

    // Randomized traffic, including redirects that wrap the address space.
    mark = delivered;
    gnt_pct = 70; lat_min = 1; lat_max = 4;
    for (int k = 0; k < 600; k++) begin
      logic        en_v, pcr_v;
      logic [31:0] pcn;
      en_v  = ($urandom_range(99) < 75);
      pcr_v = ($urandom_range(99) < 4);
      pcn   = ($urandom_range(3) == 0) ? (32'hFFFF_FFF4 + 32'($urandom_range(3))) : $urandom;
      run_cycle(en_v, pcr_v, pcn);
    end
    check_eq("random_progress", (delivered - mark) > 20, 1'b1);

    // Reset pulse mid-stream, then restart from RESET_PC.
    do_reset();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    repeat (8) run_cycle(1'b1, 1'b0, 32'h0);
    check_eq("restart_first_edge", first_valid, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
